// File: rtl/oam_dual_bank.sv
// Double-buffered sprite attribute store: narrow bus writes are assembled into whole
// entries and committed to the back bank; the renderer reads the front bank.
// Optional back-bank clear engine enabled by defining OAM_DUAL_BANK_CLEAR_EN.
module oam_dual_bank #(
  parameter int ENTRIES         = 64,
  parameter int WORD_W          = 16,
  parameter int WORDS_PER_ENTRY = 2,
  parameter logic [WORD_W*WORDS_PER_ENTRY-1:0] CLEAR_VALUE = '1,
  localparam int ENTRY_W = WORD_W * WORDS_PER_ENTRY,
  localparam int WA_W    = $clog2(ENTRIES * WORDS_PER_ENTRY),
  localparam int RA_W    = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               write_enable,
  input  logic [WA_W-1:0]    write_addr,
  input  logic [WORD_W-1:0]  write_data,
  output logic               write_error,
  input  logic               read_enable,
  input  logic [RA_W-1:0]    read_addr,
  output logic [ENTRY_W-1:0] read_data,
  output logic               read_valid,
  input  logic               swap,
  output logic               front_bank,
  input  logic               clear_start,
  output logic               busy
);

  localparam int SEQ_W = (WORDS_PER_ENTRY > 1) ? $clog2(WORDS_PER_ENTRY) : 1;
  localparam int BA_W  = RA_W + 1;

  // Physical row of entry idx in bank b; banks are stacked, not interleaved.
  function automatic logic [BA_W-1:0] phys(input logic b, input logic [RA_W-1:0] idx);
    return b ? (BA_W'(ENTRIES) + BA_W'(idx)) : BA_W'(idx);
  endfunction

  logic [ENTRY_W-1:0] mem [0:2*ENTRIES-1];

  logic [SEQ_W-1:0]   seq_idx, seq_n;
  logic [RA_W-1:0]    stage_entry, entry_n;
  logic [ENTRY_W-1:0] stage_data, stage_n, asm_data;
  logic               err_n, commit;

  logic [SEQ_W-1:0]   wr_k;
  logic [RA_W-1:0]    wr_e;
  logic               wr_oor, rd_oor;

  logic               clr_busy, clr_we, clr_go, swap_apply;
  logic [RA_W-1:0]    clr_cnt;

  logic               mem_we;
  logic [BA_W-1:0]    mem_waddr;
  logic [ENTRY_W-1:0] mem_wdata;

  assign wr_k   = SEQ_W'(write_addr % WORDS_PER_ENTRY);
  assign wr_e   = RA_W'(write_addr / WORDS_PER_ENTRY);
  assign wr_oor = {1'b0, write_addr} >= (WA_W+1)'(ENTRIES * WORDS_PER_ENTRY);
  assign rd_oor = {1'b0, read_addr}  >= (RA_W+1)'(ENTRIES);

`ifdef OAM_DUAL_BANK_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t          state, state_n;
  logic [RA_W-1:0] clr_cnt_n;
  logic            swap_pend, swap_pend_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      swap_pend <= 1'b0;
    end else begin
      state     <= state_n;
      clr_cnt   <= clr_cnt_n;
      swap_pend <= swap_pend_n;
    end
  end

  always_comb begin
    state_n     = state;
    clr_cnt_n   = clr_cnt;
    swap_pend_n = swap_pend;
    clr_we      = 1'b0;
    clr_go      = 1'b0;
    swap_apply  = swap;
    case (state)
      IDLE: begin
        if (clear_start) begin
          state_n   = CLEAR;
          clr_cnt_n = '0;
          clr_go    = 1'b1;
        end
      end
      CLEAR: begin
        clr_we     = 1'b1;
        swap_apply = 1'b0;
        if (swap) swap_pend_n = 1'b1;
        if (clr_cnt == RA_W'(ENTRIES - 1)) begin
          // A frame boundary seen during the clear lands on the edge busy drops.
          state_n     = IDLE;
          swap_apply  = swap_pend | swap;
          swap_pend_n = 1'b0;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign clr_busy = (state == CLEAR);
`else
  logic unused_clear;
  assign unused_clear = clear_start;
  assign clr_busy     = 1'b0;
  assign clr_we       = 1'b0;
  assign clr_go       = 1'b0;
  assign clr_cnt      = '0;
  assign swap_apply   = swap;
`endif

  assign busy = clr_busy;

  // Staged slices with the incoming word dropped into slice k (word 0 in MSBs).
  always_comb begin
    asm_data = stage_data;
    asm_data[(WORDS_PER_ENTRY - 1 - int'(wr_k)) * WORD_W +: WORD_W] = write_data;
  end

  always_comb begin
    seq_n   = seq_idx;
    entry_n = stage_entry;
    stage_n = stage_data;
    err_n   = 1'b0;
    commit  = 1'b0;
    if (write_enable) begin
      if (clr_busy || wr_oor) begin
        err_n = 1'b1;
      end else if (wr_k == '0 || (wr_k == seq_idx && wr_e == stage_entry)) begin
        err_n   = (wr_k == '0) && (seq_idx != '0);
        stage_n = asm_data;
        entry_n = wr_e;
        if (wr_k == SEQ_W'(WORDS_PER_ENTRY - 1)) begin
          commit = 1'b1;
          seq_n  = '0;
        end else begin
          seq_n = wr_k + SEQ_W'(1);
        end
      end else begin
        err_n = 1'b1;
        seq_n = '0;
      end
    end
    if (clr_go) seq_n = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_idx     <= '0;
      stage_entry <= '0;
      stage_data  <= '0;
      write_error <= 1'b0;
      front_bank  <= 1'b0;
    end else begin
      seq_idx     <= seq_n;
      stage_entry <= entry_n;
      stage_data  <= stage_n;
      write_error <= err_n;
      if (swap_apply) front_bank <= ~front_bank;
    end
  end

  // Commits and clears both target the bank that is back before this edge.
  assign mem_we    = commit | clr_we;
  assign mem_waddr = clr_we ? phys(~front_bank, clr_cnt) : phys(~front_bank, wr_e);
  assign mem_wdata = clr_we ? CLEAR_VALUE : asm_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= read_enable;
      if (read_enable)
        read_data <= rd_oor ? '0 : mem[phys(front_bank, read_addr)];
    end
  end

endmodule

// File: tb/tb_oam_dual_bank.sv
// Directed vector bench for oam_dual_bank: table of per-cycle stimulus/expectations
// plus hand sequences for reset mid-assembly and the optional clear engine.
module tb_oam_dual_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable = 1'b0;
  logic [6:0]  write_addr = '0;
  logic [15:0] write_data = '0;
  logic        write_error;
  logic        read_enable = 1'b0;
  logic [5:0]  read_addr = '0;
  logic [31:0] read_data;
  logic        read_valid;
  logic        swap = 1'b0;
  logic        front_bank;
  logic        clear_start = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;

  oam_dual_bank dut (
    .clk(clk), .reset(reset),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .write_error(write_error),
    .read_enable(read_enable), .read_addr(read_addr), .read_data(read_data),
    .read_valid(read_valid),
    .swap(swap), .front_bank(front_bank),
    .clear_start(clear_start), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [6:0]  wa;
    logic [15:0] wd;
    logic        re;
    logic [5:0]  ra;
    logic        sw;
    logic        e_err;
    logic        e_rv;
    logic        e_front;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic we, input logic [6:0] wa, input logic [15:0] wd,
                             input logic re, input logic [5:0] ra, input logic sw,
                             input logic e_err, input logic e_rv, input logic e_front,
                             input logic chk_rd, input logic [31:0] e_rd);
    vec_t r;
    r.we = we; r.wa = wa; r.wd = wd; r.re = re; r.ra = ra; r.sw = sw;
    r.e_err = e_err; r.e_rv = e_rv; r.e_front = e_front; r.chk_rd = chk_rd; r.e_rd = e_rd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_enable = 1'b0; read_enable = 1'b0; swap = 1'b0; clear_start = 1'b0;
  endtask

  initial begin
    // we    wa   wd        re ra sw  err rv fr chk rd
    vecs.push_back(v(0, 0,  16'h0000, 0, 0, 0, 0, 0, 0, 1, 32'h0));
    vecs.push_back(v(1, 10, 16'h1234, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(v(1, 11, 16'hABCD, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(v(0, 0,  16'h0000, 0, 0, 1, 0, 0, 1, 0, 32'h0));
    vecs.push_back(v(0, 0,  16'h0000, 1, 5, 0, 0, 1, 1, 1, 32'h1234ABCD));
    vecs.push_back(v(0, 0,  16'h0000, 0, 0, 0, 0, 0, 1, 1, 32'h1234ABCD));
    vecs.push_back(v(1, 6,  16'h3333, 0, 0, 0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(v(1, 7,  16'h4444, 0, 0, 0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(v(1, 8,  16'h5555, 0, 0, 0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(v(1, 9,  16'h6666, 0, 0, 0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(v(0, 0,  16'h0000, 0, 0, 1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(v(1, 6,  16'h1111, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(v(1, 7,  16'h2222, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(v(0, 0,  16'h0000, 1, 3, 0, 0, 1, 0, 1, 32'h33334444));
    vecs.push_back(v(0, 0,  16'h0000, 0, 0, 1, 0, 0, 1, 0, 32'h0));
    vecs.push_back(v(0, 0,  16'h0000, 1, 3, 0, 0, 1, 1, 1, 32'h11112222));
    vecs.push_back(v(1, 6,  16'h7777, 0, 0, 0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(v(1, 9,  16'h8888, 0, 0, 0, 1, 0, 1, 0, 32'h0));
    vecs.push_back(v(0, 0,  16'h0000, 0, 0, 1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(v(0, 0,  16'h0000, 1, 4, 0, 0, 1, 0, 1, 32'h55556666));
    vecs.push_back(v(1, 6,  16'h9999, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(v(1, 8,  16'hAAAA, 0, 0, 0, 1, 0, 0, 0, 32'h0));
    vecs.push_back(v(1, 9,  16'hBBBB, 0, 0, 0, 0, 0, 0, 0, 32'h0));
    vecs.push_back(v(0, 0,  16'h0000, 0, 0, 1, 0, 0, 1, 0, 32'h0));
    vecs.push_back(v(0, 0,  16'h0000, 1, 4, 0, 0, 1, 1, 1, 32'hAAAABBBB));
    vecs.push_back(v(0, 0,  16'h0000, 1, 3, 0, 0, 1, 1, 1, 32'h11112222));
    vecs.push_back(v(1, 6,  16'hCCCC, 0, 0, 0, 0, 0, 1, 0, 32'h0));
    vecs.push_back(v(1, 7,  16'hDDDD, 1, 3, 1, 0, 1, 0, 1, 32'h11112222));
    vecs.push_back(v(0, 0,  16'h0000, 1, 3, 0, 0, 1, 0, 1, 32'hCCCCDDDD));
    vecs.push_back(v(0, 0,  16'h0000, 0, 0, 1, 0, 0, 1, 0, 32'h0));
    vecs.push_back(v(0, 0,  16'h0000, 0, 0, 1, 0, 0, 0, 0, 32'h0));
    vecs.push_back(v(1, 11, 16'hEEEE, 0, 0, 0, 1, 0, 0, 0, 32'h0));
    vecs.push_back(v(0, 0,  16'h0000, 0, 0, 0, 0, 0, 0, 1, 32'hCCCCDDDD));

    #1;
    chk("rst_front", 64'(front_bank), 64'd0);
    chk("rst_rvalid", 64'(read_valid), 64'd0);
    chk("rst_err", 64'(write_error), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick(); tick();
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      write_enable = vecs[i].we; write_addr = vecs[i].wa; write_data = vecs[i].wd;
      read_enable  = vecs[i].re; read_addr  = vecs[i].ra; swap = vecs[i].sw;
      tick();
      idle_inputs();
      chk($sformatf("v%0d_err", i), 64'(write_error), 64'(vecs[i].e_err));
      chk($sformatf("v%0d_rvalid", i), 64'(read_valid), 64'(vecs[i].e_rv));
      chk($sformatf("v%0d_front", i), 64'(front_bank), 64'(vecs[i].e_front));
      if (vecs[i].chk_rd)
        chk($sformatf("v%0d_rdata", i), 64'(read_data), 64'(vecs[i].e_rd));
    end

    // Reset in the middle of an assembly, with front=1 and read_data non-zero.
    swap = 1'b1; tick(); idle_inputs();
    chk("pre_rst_front", 64'(front_bank), 64'd1);
    write_enable = 1'b1; write_addr = 7'd6; write_data = 16'h1357; tick(); idle_inputs();
    reset = 1'b1; #1;
    chk("mid_rst_front", 64'(front_bank), 64'd0);
    chk("mid_rst_rdata", 64'(read_data), 64'd0);
    tick();
    reset = 1'b0;
    write_enable = 1'b1; write_addr = 7'd7; write_data = 16'h2468; tick(); idle_inputs();
    chk("post_rst_orphan_err", 64'(write_error), 64'd1);

`ifdef OAM_DUAL_BANK_CLEAR_EN
    begin
      int n;
      logic early_toggle;
      n = 0;
      early_toggle = 1'b0;
      clear_start = 1'b1; tick(); idle_inputs();
      chk("clr_busy_rise", 64'(busy), 64'd1);
      while (busy && n < 200) begin
        n++;
        if (n == 10) swap = 1'b1;
        if (n == 20) begin write_enable = 1'b1; write_addr = 7'd0; write_data = 16'h0F0F; end
        if (n == 30) clear_start = 1'b1;
        tick();
        idle_inputs();
        if (n == 20) chk("clr_write_err", 64'(write_error), 64'd1);
        if (busy && front_bank) early_toggle = 1'b1;
      end
      chk("clr_busy_cycles", 64'(n), 64'd64);
      chk("clr_swap_held", 64'(early_toggle), 64'd0);
      chk("clr_front_after", 64'(front_bank), 64'd1);
      tick();
      chk("clr_busy_stays_low", 64'(busy), 64'd0);
      for (int e = 0; e < 64; e++) begin
        read_enable = 1'b1; read_addr = 6'(e); tick(); idle_inputs();
        chk($sformatf("clr_entry%0d", e), 64'(read_data), 64'hFFFFFFFF);
      end
    end
`else
    clear_start = 1'b1; tick(); idle_inputs();
    chk("noclr_busy", 64'(busy), 64'd0);
    swap = 1'b1; tick(); idle_inputs();
    chk("noclr_swap_immediate", 64'(front_bank), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oam_dual_bank.md
Name: oam_dual_bank

Overview:
- Parametrised successor to the single-bank OAM store for the sprite pipeline.
- Accepts narrow CPU/bus writes and assembles them into full sprite entries in a staging register. Each completed entry is committed atomically to a back bank.
- The sprite engine reads whole entries synchronously from a front bank.
- Banks swap on a frame-boundary pulse, so the renderer never sees a half-updated sprite.

Parameters:
- ENTRIES, 64, number of sprite entries per bank.
- WORD_W, 16, width of one bus write word.
- WORDS_PER_ENTRY, 2, bus words per entry; word 0 is the most-significant slice.
- CLEAR_VALUE, all ones (ENTRY_W bits), entry value written by the clear engine; Y=0xFF hides the sprite.
- Derived: ENTRY_W = WORD_W*WORDS_PER_ENTRY; WA_W = $clog2(ENTRIES*WORDS_PER_ENTRY); RA_W = $clog2(ENTRIES).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- write_enable  in  1  bus word write strobe.
- write_addr  in  WA_W  word address = entry*WORDS_PER_ENTRY + word index.
- write_data  in  WORD_W  bus word.
- write_error  out  1  one-cycle pulse on a rejected or abandoned write.
- read_enable  in  1  entry read request.
- read_addr  in  RA_W  entry index.
- read_data  out  ENTRY_W  entry, word 0 in the MSBs.
- read_valid  out  1  read_data valid; 1 cycle after read_enable.
- swap  in  1  frame-boundary pulse; exchanges front and back banks.
- front_bank  out  1  index of the bank currently read.
- clear_start  in  1  starts a back-bank clear (optional feature).
- busy  out  1  clear engine active (optional feature).

Behaviour:
- Reset (asynchronous, active-high) sets:
  - front_bank=0, read_data=0, read_valid=0, write_error=0, busy=0;
  - staging empty: seq_idx=0, stage_entry=0;
  - no pending swap.
  - RAM contents are not reset.
  - Reset mid-assembly or mid-clear discards all progress.
- Storage:
  - 2*ENTRIES entries of ENTRY_W bits; bank b occupies entries b*ENTRIES..b*ENTRIES+ENTRIES-1.
  - Inferred as block RAM.
- Write assembly (write_enable=1; word index k = write_addr % WORDS_PER_ENTRY, entry e = write_addr / WORDS_PER_ENTRY):
  - write_addr >= ENTRIES*WORDS_PER_ENTRY: ignored; write_error pulses.
  - k==0: latch word into slice 0, stage_entry<=e, seq_idx<=1. If a partial entry was pending (seq_idx!=0), it is discarded and write_error pulses.
  - k==seq_idx and e==stage_entry: latch slice k, seq_idx<=seq_idx+1.
  - Any other k: word dropped, staging cleared (seq_idx<=0), write_error pulses.
  - When the last word (k==WORDS_PER_ENTRY-1) is accepted, the full entry (staged slices plus the current word) is written to back bank entry e on that same edge, and seq_idx<=0.
  - WORDS_PER_ENTRY==1: every in-range write commits directly.
- Swap:
  - On a swap pulse, front_bank toggles at that edge; staging is kept.
  - A commit on the same edge writes into the pre-swap back bank, which becomes front, so the commit is immediately visible.
  - Consecutive swap pulses toggle every cycle.
  - Double buffering does not copy data; software rewrites the back bank each frame.
- Read:
  - Synchronous, 1-cycle latency: read_data <= entry read_addr of the front bank sampled at the read_enable edge; read_valid <= read_enable.
  - read and swap on the same edge: the read returns the old front bank.
  - read_addr >= ENTRIES returns 0.
  - read_data holds its value when read_enable=0.
  - Read of an entry being committed on the same edge in the same bank (only possible via swap+commit) returns the old contents.

Optional Feature:
- Macro: OAM_DUAL_BANK_CLEAR_EN.
- Defined:
  - FSM IDLE -> CLEAR -> IDLE.
  - clear_start in IDLE: busy<=1, counter<=0.
  - CLEAR writes CLEAR_VALUE to back-bank entry counter, one per cycle, for ENTRIES cycles.
  - After entry ENTRIES-1, return to IDLE with busy<=0.
  - While busy:
    - bus writes are dropped and pulse write_error;
    - clear_start is ignored;
    - a swap pulse is held pending and applied on the edge busy falls.
  - Staging is cleared at clear start.
- Undefined: no FSM; clear_start ignored; busy tied 0; swap always immediate.

Test Plan:
- Reset, write addr 10=0x1234 then 11=0xABCD, swap, read entry 5 -> read_valid one cycle later, read_data=0x1234ABCD, front_bank=1, no write_error.
- Commit entry 3=0x11112222 to back, read entry 3 before swap -> old front contents; after swap -> 0x11112222.
- Write addr 6 (k=0, e=3) then addr 9 (k=1, e=4) -> write_error pulse on second write; entry 4 unchanged after swap.
- Write addr 6, then addr 8 (new k=0) -> write_error pulse; complete with addr 9 -> entry 4 commits, entry 3 untouched.
- Last word written on the same edge as swap, read next cycle -> new value visible from the new front bank; a read issued on the swap edge returns the old front data.
- OAM_DUAL_BANK_CLEAR_EN: clear_start, swap at cycle 10 -> busy high 64 cycles, front_bank toggles on the edge busy falls, all entries read 0xFFFFFFFF; a write during busy pulses write_error.
